// File: rtl/rv32im_types.sv
// rv32im_types
//   Shared RV32IM decode types: major opcode encodings and the branch
//   funct3 sub-codes. No ports; imported by the branch execution unit.
package rv32im_types;

  typedef enum logic [6:0] {
    op_b_lui   = 7'b0110111,
    op_b_auipc = 7'b0010111,
    op_b_jal   = 7'b1101111,
    op_b_jalr  = 7'b1100111,
    op_b_br    = 7'b1100011,
    op_b_load  = 7'b0000011,
    op_b_store = 7'b0100011,
    op_b_imm   = 7'b0010011,
    op_b_reg   = 7'b0110011,
    op_b_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    branch_f3_beq  = 3'b000,
    branch_f3_bne  = 3'b001,
    branch_f3_blt  = 3'b100,
    branch_f3_bge  = 3'b101,
    branch_f3_bltu = 3'b110,
    branch_f3_bgeu = 3'b111
  } branch_f3_t;

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo
//   Small result buffer holding link values awaiting the CDB.
//   Ports:
//     clk, rst        clock, async active-high reset
//     flush           drop every held entry (wins over push/pop)
//     push, push_data write one entry; taken only if not full or popping
//     pop             remove head (ignored when empty)
//     head_data       current head payload (stale when empty)
//     empty, full     occupancy flags
module resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_push)
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_push && !do_pop)
        count_d = count_q + 1'b1;
      else if (do_pop && !do_push)
        count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count_q != 0.
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/branch_exec_unit.sv
// branch_exec_unit
//   Resolves JAL/JALR/conditional branches in the accept cycle, queues the
//   link value for the CDB, and emits one-cycle redirect and predictor-update
//   pulses plus saturating branch/mispredict counters.
//   Ports:
//     clk, rst, flush                      clock, async reset, ROB flush
//     issue_*                              branch offered by reservation station
//     cdb_valid/ready/data/tag             result-buffer head handshake
//     redirect_valid/pc/tag                mispredict pulse
//     upd_valid/pc/taken/target/opcode     predictor training pulse
//     br_count, mispred_count              performance counters
module branch_exec_unit
  import rv32im_types::*;
#(
  parameter int ROB_DEPTH  = 16,
  parameter int RESP_DEPTH = 2,
  parameter int CNT_W      = 32,
  localparam int TW        = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [31:0]      issue_instr,
  input  logic [31:0]      issue_pc,
  input  logic [31:0]      issue_imm,
  input  logic [31:0]      issue_rs1_v,
  input  logic [31:0]      issue_rs2_v,
  input  logic [TW-1:0]    issue_tag,
  input  logic             issue_pred_taken,
  input  logic [31:0]      issue_pred_target,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [31:0]      cdb_data,
  output logic [TW-1:0]    cdb_tag,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [TW-1:0]    redirect_tag,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic [6:0]       upd_opcode,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int PLW = 32 + TW;

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic           is_br, taken, mispredict, accept;
  logic [31:0]    target, link, actual_next;
  logic [PLW-1:0] head;
  logic           fifo_empty, fifo_full, cdb_pop;
  logic           unused_instr_bits;

  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [TW-1:0]    redirect_tag_q, redirect_tag_d;
  logic             upd_valid_q, upd_valid_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic [31:0]      upd_target_q, upd_target_d;
  logic [6:0]       upd_opcode_q, upd_opcode_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  assign opcode = issue_instr[6:0];
  assign funct3 = issue_instr[14:12];
  assign unused_instr_bits = ^{issue_instr[31:15], issue_instr[11:7]};

  always_comb begin
    is_br  = 1'b0;
    taken  = 1'b0;
    target = issue_pc + issue_imm;
    case (opcode)
      op_b_jal: begin
        is_br = 1'b1;
        taken = 1'b1;
      end
      op_b_jalr: begin
        is_br  = 1'b1;
        taken  = 1'b1;
        target = (issue_rs1_v + issue_imm) & ~32'd1;
      end
      op_b_br: begin
        is_br = 1'b1;
        case (funct3)
          branch_f3_beq:  taken = (issue_rs1_v == issue_rs2_v);
          branch_f3_bne:  taken = (issue_rs1_v != issue_rs2_v);
          branch_f3_blt:  taken = ($signed(issue_rs1_v) <  $signed(issue_rs2_v));
          branch_f3_bge:  taken = ($signed(issue_rs1_v) >= $signed(issue_rs2_v));
          branch_f3_bltu: taken = (issue_rs1_v <  issue_rs2_v);
          branch_f3_bgeu: taken = (issue_rs1_v >= issue_rs2_v);
          default:        taken = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign link        = issue_pc + 32'd4;
  assign actual_next = taken ? target : link;
  assign mispredict  = (taken != issue_pred_taken) ||
                       (taken && (target != issue_pred_target));

  assign cdb_pop     = cdb_valid && cdb_ready;
  assign issue_ready = !fifo_full || cdb_pop;
  assign accept      = issue_valid && issue_ready && !flush;

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (PLW)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (accept),
    .push_data ({link, issue_tag}),
    .pop       (cdb_pop),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign cdb_valid = !fifo_empty;
  assign cdb_data  = fifo_empty ? 32'd0 : head[PLW-1:TW];
  assign cdb_tag   = fifo_empty ? '0    : head[TW-1:0];

  // Payload registers load zero whenever their pulse is not firing, so
  // the data outputs are already zero while the valid is low.
  always_comb begin
    redirect_valid_d = accept && mispredict;
    redirect_pc_d    = redirect_valid_d ? actual_next : 32'd0;
    redirect_tag_d   = redirect_valid_d ? issue_tag   : '0;

    upd_valid_d  = accept && is_br;
    upd_pc_d     = upd_valid_d ? issue_pc : 32'd0;
    upd_taken_d  = upd_valid_d && taken;
    upd_target_d = upd_valid_d ? target   : 32'd0;
    upd_opcode_d = upd_valid_d ? opcode   : 7'd0;

    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_valid_d && (br_cnt_q != {CNT_W{1'b1}}))
      br_cnt_d = br_cnt_q + 1'b1;
    if (redirect_valid_d && (mis_cnt_q != {CNT_W{1'b1}}))
      mis_cnt_d = mis_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      redirect_tag_q   <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_target_q     <= '0;
      upd_opcode_q     <= '0;
      br_cnt_q         <= '0;
      mis_cnt_q        <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_tag_q   <= redirect_tag_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      upd_target_q     <= upd_target_d;
      upd_opcode_q     <= upd_opcode_d;
      br_cnt_q         <= br_cnt_d;
      mis_cnt_q        <= mis_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign redirect_tag   = redirect_tag_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign upd_opcode     = upd_opcode_q;
  assign br_count       = br_cnt_q;
  assign mispred_count  = mis_cnt_q;

endmodule

// File: tb/tb_branch_exec_unit.sv
module tb_branch_exec_unit;

  localparam int TW = 4;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_REG  = 7'b0110011;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          issue_valid, issue_ready;
  logic [31:0]   issue_instr, issue_pc, issue_imm, issue_rs1_v, issue_rs2_v;
  logic [TW-1:0] issue_tag;
  logic          issue_pred_taken;
  logic [31:0]   issue_pred_target;
  logic          cdb_valid, cdb_ready;
  logic [31:0]   cdb_data;
  logic [TW-1:0] cdb_tag;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [TW-1:0] redirect_tag;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic [31:0]   upd_target;
  logic [6:0]    upd_opcode;
  logic [31:0]   br_count, mispred_count;

  always #5 clk = ~clk;

  branch_exec_unit dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_instr       (issue_instr),
    .issue_pc          (issue_pc),
    .issue_imm         (issue_imm),
    .issue_rs1_v       (issue_rs1_v),
    .issue_rs2_v       (issue_rs2_v),
    .issue_tag         (issue_tag),
    .issue_pred_taken  (issue_pred_taken),
    .issue_pred_target (issue_pred_target),
    .cdb_valid         (cdb_valid),
    .cdb_ready         (cdb_ready),
    .cdb_data          (cdb_data),
    .cdb_tag           (cdb_tag),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_tag      (redirect_tag),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .upd_opcode        (upd_opcode),
    .br_count          (br_count),
    .mispred_count     (mispred_count)
  );

  typedef struct packed { logic [31:0] data; logic [TW-1:0] tag; } cdb_exp_t;
  typedef struct packed { logic [31:0] pc;   logic [TW-1:0] tag; } red_exp_t;
  typedef struct packed {
    logic [31:0] pc; logic taken; logic [31:0] target; logic [6:0] opcode;
  } upd_exp_t;

  cdb_exp_t cdb_q[$];
  red_exp_t red_q[$];
  upd_exp_t upd_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_br  = 0;
  logic [31:0] exp_mis = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output valid with no expectation queued (t=%0t)", name, $time);
  endfunction

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (cdb_valid) begin
        if (cdb_q.size() == 0) unexpected("cdb");
        else begin
          chk("cdb_data", cdb_data, cdb_q[0].data);
          chk("cdb_tag",  cdb_tag,  cdb_q[0].tag);
          if (cdb_ready) void'(cdb_q.pop_front());
        end
      end else chk("cdb_idle_zero", {cdb_data, cdb_tag}, 64'd0);

      if (redirect_valid) begin
        if (red_q.size() == 0) unexpected("redirect");
        else begin
          chk("redirect_pc",  redirect_pc,  red_q[0].pc);
          chk("redirect_tag", redirect_tag, red_q[0].tag);
          void'(red_q.pop_front());
        end
      end else chk("redirect_idle_zero", {redirect_pc, redirect_tag}, 64'd0);

      if (upd_valid) begin
        if (upd_q.size() == 0) unexpected("upd");
        else begin
          chk("upd_pc",     upd_pc,     upd_q[0].pc);
          chk("upd_taken",  upd_taken,  upd_q[0].taken);
          chk("upd_target", upd_target, upd_q[0].target);
          chk("upd_opcode", upd_opcode, upd_q[0].opcode);
          void'(upd_q.pop_front());
        end
      end else chk("upd_idle_zero", {upd_pc, upd_taken, upd_target, upd_opcode}, 64'd0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_issue(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [TW-1:0] tag, input logic pt, input logic [31:0] ptgt,
                          input logic exp_taken, input logic [31:0] exp_target,
                          input logic exp_redir);
    logic accepted;
    issue_instr       = {17'd0, f3, 5'd0, op};
    issue_pc          = pc;
    issue_imm         = imm;
    issue_rs1_v       = rs1;
    issue_rs2_v       = rs2;
    issue_tag         = tag;
    issue_pred_taken  = pt;
    issue_pred_target = ptgt;
    issue_valid       = 1'b1;
    accepted          = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (issue_ready) begin
        accepted = 1'b1;
        cdb_q.push_back('{data: pc + 32'd4, tag: tag});
        if (exp_redir) begin
          red_q.push_back('{pc: exp_taken ? exp_target : pc + 32'd4, tag: tag});
          exp_mis++;
        end
        if (op == OP_JAL || op == OP_JALR || op == OP_BR) begin
          upd_q.push_back('{pc: pc, taken: exp_taken, target: exp_target, opcode: op});
          exp_br++;
        end
      end
      @(posedge clk);
    end
    #1;
    issue_valid = 1'b0;
    if (!accepted) chk("issue_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_cdb"},      {cdb_valid, cdb_data, cdb_tag}, 64'd0);
    chk({pfx, "_redirect"}, {redirect_valid, redirect_pc, redirect_tag}, 64'd0);
    chk({pfx, "_upd"},      {upd_valid, upd_pc, upd_taken, upd_target, upd_opcode}, 64'd0);
    chk({pfx, "_counters"}, {br_count, mispred_count}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; cdb_ready = 1'b1;
    issue_instr = 0; issue_pc = 0; issue_imm = 0; issue_rs1_v = 0; issue_rs2_v = 0;
    issue_tag = 0; issue_pred_taken = 0; issue_pred_target = 0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", issue_ready, 1);

    // op, f3, pc, imm, rs1, rs2, tag, pred_taken, pred_target, exp_taken, exp_target, exp_redirect
    do_issue(OP_BR,   3'b000, 32'h100, 32'h20,       32'd5,        32'd5,        4'd3,  0, 32'h0,   1, 32'h120, 1);
    chk("mispred_after_beq", mispred_count, 1);
    do_issue(OP_BR,   3'b110, 32'h200, 32'h40,       32'hFFFFFFFF, 32'd1,        4'd4,  0, 32'h0,   0, 32'h240, 0);
    do_issue(OP_JALR, 3'b000, 32'h300, 32'h0,        32'h203,      32'd0,        4'd5,  1, 32'h202, 1, 32'h202, 0);
    do_issue(OP_JAL,  3'b000, 32'h400, 32'hFFFFFFF0, 32'd0,        32'd0,        4'd6,  0, 32'h0,   1, 32'h3F0, 1);
    do_issue(OP_BR,   3'b100, 32'h500, 32'h8,        32'hFFFFFFFF, 32'd1,        4'd7,  0, 32'h0,   1, 32'h508, 1);
    do_issue(OP_BR,   3'b001, 32'h600, 32'h10,       32'd1,        32'd1,        4'd8,  1, 32'h610, 0, 32'h610, 1);
    do_issue(OP_BR,   3'b111, 32'h700, 32'h20,       32'd1,        32'hFFFFFFFF, 4'd9,  0, 32'h0,   0, 32'h720, 0);
    do_issue(OP_BR,   3'b101, 32'h800, 32'h100,      32'd1,        32'hFFFFFFFF, 4'd10, 1, 32'h900, 1, 32'h900, 0);
    do_issue(OP_BR,   3'b010, 32'h900, 32'h30,       32'd7,        32'd9,        4'd11, 0, 32'h0,   0, 32'h930, 0);
    do_issue(OP_REG,  3'b000, 32'hA00, 32'h4,        32'd1,        32'd2,        4'd12, 0, 32'h0,   0, 32'hA04, 0);
    do_issue(OP_BR,   3'b000, 32'hB00, 32'h40,       32'd1,        32'd2,        4'd13, 1, 32'hB40, 0, 32'hB40, 1);
    do_issue(OP_BR,   3'b000, 32'hC00, 32'h40,       32'd3,        32'd3,        4'd14, 1, 32'hC80, 1, 32'hC40, 1);
    repeat (3) @(posedge clk); #1;
    chk("br_count_directed", br_count, exp_br);
    chk("mispred_count_directed", mispred_count, exp_mis);

    // Back-pressure: two entries fill the buffer, a third waits for the CDB.
    cdb_ready = 1'b0;
    do_issue(OP_JAL, 3'b000, 32'h1000, 32'h10, 0, 0, 4'd1, 1, 32'h1010, 1, 32'h1010, 0);
    do_issue(OP_JAL, 3'b000, 32'h1100, 32'h10, 0, 0, 4'd2, 1, 32'h1110, 1, 32'h1110, 0);
    @(negedge clk);
    chk("ready_low_when_full", issue_ready, 0);
    @(posedge clk); #1;
    fork
      do_issue(OP_JAL, 3'b000, 32'h1200, 32'h10, 0, 0, 4'd3, 1, 32'h1210, 1, 32'h1210, 0);
      begin
        repeat (3) @(posedge clk);
        #1 cdb_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("drained_in_order", cdb_q.size(), 0);

    // Flush with a same-cycle (mispredicting) issue while two entries are held.
    cdb_ready = 1'b0;
    do_issue(OP_JAL, 3'b000, 32'h2000, 32'h10, 0, 0, 4'd5, 1, 32'h2010, 1, 32'h2010, 0);
    do_issue(OP_JAL, 3'b000, 32'h2100, 32'h10, 0, 0, 4'd6, 1, 32'h2110, 1, 32'h2110, 0);
    issue_instr = {17'd0, 3'b000, 5'd0, OP_BR};
    issue_pc = 32'h2200; issue_imm = 32'h40; issue_rs1_v = 32'd9; issue_rs2_v = 32'd9;
    issue_tag = 4'd7; issue_pred_taken = 1'b0; issue_pred_target = 32'h0;
    issue_valid = 1'b1; flush = 1'b1; cdb_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; issue_valid = 1'b0;
    cdb_q.delete();
    @(negedge clk);
    chk("flush_cdb_valid", cdb_valid, 0);
    chk("flush_no_redirect", redirect_valid, 0);
    chk("flush_no_upd", upd_valid, 0);
    chk("flush_br_count", br_count, exp_br);
    chk("flush_mispred_count", mispred_count, exp_mis);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a stall with a redirect pulse live.
    cdb_ready = 1'b0;
    do_issue(OP_JAL, 3'b000, 32'h3000, 32'h10, 0, 0, 4'd1, 0, 32'h0, 1, 32'h3010, 1);
    do_issue(OP_JAL, 3'b000, 32'h3100, 32'h10, 0, 0, 4'd2, 0, 32'h0, 1, 32'h3110, 1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    cdb_q.delete(); red_q.delete(); upd_q.delete();
    exp_br = 0; exp_mis = 0;
    @(posedge clk);
    #3 rst = 1'b0; cdb_ready = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midstall_reset", issue_ready, 1);
    do_issue(OP_BR, 3'b000, 32'h4000, 32'h20, 32'd1, 32'd1, 4'd9, 0, 32'h0, 1, 32'h4020, 1);
    repeat (3) @(posedge clk); #1;
    chk("br_count_after_reset", br_count, exp_br);
    chk("mispred_count_after_reset", mispred_count, exp_mis);

    chk("cdb_queue_empty", cdb_q.size(), 0);
    chk("redirect_queue_empty", red_q.size(), 0);
    chk("upd_queue_empty", upd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
